// File: rtl/vga_pkg.sv
// Shared VGA constants, RGB565 field layout, colour constants and the small helpers
// used by the image-window datapath and its origin controller.
package vga_pkg;

    localparam int H_DISP = 640;
    localparam int V_DISP = 480;
    localparam int CH_W   = 10;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    localparam logic [3*CH_W-1:0] BLACK = '0;
    localparam logic [3*CH_W-1:0] WHITE = '1;
    localparam logic [3*CH_W-1:0] RED   = {{CH_W{1'b1}}, {(2*CH_W){1'b0}}};
    localparam logic [3*CH_W-1:0] GREEN = {{CH_W{1'b0}}, {CH_W{1'b1}}, {CH_W{1'b0}}};
    localparam logic [3*CH_W-1:0] BLUE  = {{(2*CH_W){1'b0}}, {CH_W{1'b1}}};

    typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_e;

    typedef struct packed {
        logic [9:0] pos;
        dir_e       dir;
    } axis_t;

    // MSB replication keeps full scale at full scale (0x1F -> 0x3FF).
    function automatic logic [3*CH_W-1:0] rgb565_expand(input logic [15:0] w);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        r = w[R_MSB:R_LSB];
        g = w[G_MSB:G_LSB];
        b = w[B_MSB:B_LSB];
        return {r, r, g, g[5:2], b, b};
    endfunction

    function automatic axis_t bounce_step(input axis_t cur, input logic [9:0] limit,
                                          input logic [9:0] step);
        axis_t nxt;
        nxt = cur;
        if (cur.dir == DIR_POS) begin
            if (({1'b0, cur.pos} + {1'b0, step}) >= {1'b0, limit}) begin
                nxt.pos = limit;
                nxt.dir = DIR_NEG;
            end else begin
                nxt.pos = cur.pos + step;
            end
        end else if (cur.pos <= step) begin
            nxt.pos = '0;
            nxt.dir = DIR_POS;
        end else begin
            nxt.pos = cur.pos - step;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/vga_image_window_if.sv
// Pixel-side bus of the image window: timing coordinates in, ROM port, DAC pixel and debug origin out.
interface vga_image_window_if #(
    parameter int ADDR_W   = 14,
    parameter int OUT_CH_W = 10
) ();
    logic [9:0]            pixel_xpos;
    logic [9:0]            pixel_ypos;
    logic                  move_en;
    logic [3*OUT_CH_W-1:0] bg_color;
    logic [3*OUT_CH_W-1:0] border_color;
    logic [ADDR_W-1:0]     rom_addr;
    logic [15:0]           rom_data;
    logic [3*OUT_CH_W-1:0] pixel_data;
    logic [9:0]            win_x0;
    logic [9:0]            win_y0;

    modport slave (
        input  pixel_xpos, pixel_ypos, move_en, bg_color, border_color, rom_data,
        output rom_addr, pixel_data, win_x0, win_y0
    );

    modport master (
        output pixel_xpos, pixel_ypos, move_en, bg_color, border_color, rom_data,
        input  rom_addr, pixel_data, win_x0, win_y0
    );
endinterface

// File: rtl/vga_win_origin.sv
// Window origin controller: detects the frame start and bounces the origin once per frame
// so the window only ever moves between frames.
module vga_win_origin #(
    parameter int H_DISP = vga_pkg::H_DISP,
    parameter int V_DISP = vga_pkg::V_DISP,
    parameter int IMG_W  = 240,
    parameter int IMG_H  = 40,
    parameter int X_INIT = 100,
    parameter int Y_INIT = 50,
    parameter int STEP   = 2
) (
    input  logic       driver_clk,
    input  logic       sys_rst_n,
    input  logic [9:0] pixel_xpos_i,
    input  logic [9:0] pixel_ypos_i,
    input  logic       move_en_i,
    output logic [9:0] win_x0_o,
    output logic [9:0] win_y0_o
);
    import vga_pkg::*;

    localparam logic [9:0] X_LIMIT = 10'(H_DISP - IMG_W);
    localparam logic [9:0] Y_LIMIT = 10'(V_DISP - IMG_H);
    localparam logic [9:0] STEP_10 = 10'(STEP);

    logic  atOrigin_d, atOrigin_q;
    logic  frameStart;
    axis_t axisX_d, axisX_q;
    axis_t axisY_d, axisY_q;

    always_ff @(posedge driver_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            atOrigin_q <= 1'b0;
            axisX_q    <= '{pos: 10'(X_INIT), dir: DIR_POS};
            axisY_q    <= '{pos: 10'(Y_INIT), dir: DIR_POS};
        end else begin
            atOrigin_q <= atOrigin_d;
            axisX_q    <= axisX_d;
            axisY_q    <= axisY_d;
        end
    end

    // Only the first cycle at (0,0) counts, so a driver lingering there moves the window once.
    always_comb begin
        atOrigin_d = (pixel_xpos_i == '0) && (pixel_ypos_i == '0);
        frameStart = atOrigin_d && !atOrigin_q;
        axisX_d    = axisX_q;
        axisY_d    = axisY_q;
        if (frameStart && move_en_i) begin
            axisX_d = bounce_step(axisX_q, X_LIMIT, STEP_10);
            axisY_d = bounce_step(axisY_q, Y_LIMIT, STEP_10);
        end
    end

    assign win_x0_o = axisX_q.pos;
    assign win_y0_o = axisY_q.pos;

endmodule

// File: rtl/vga_image_window.sv
// Places an IMG_W x IMG_H RGB565 ROM image in a (optionally bouncing) window with a border,
// filling the rest of the active area with a background colour. Latency is 2+ROM_LAT cycles.
module vga_image_window #(
    parameter int H_DISP   = vga_pkg::H_DISP,
    parameter int V_DISP   = vga_pkg::V_DISP,
    parameter int IMG_W    = 240,
    parameter int IMG_H    = 40,
    parameter int ADDR_W   = 14,
    parameter int OUT_CH_W = vga_pkg::CH_W,
    parameter int ROM_LAT  = 1,
    parameter int X_INIT   = 100,
    parameter int Y_INIT   = 50,
    parameter int STEP     = 2,
    parameter int BORDER_W = 2
) (
    input  logic              driver_clk,
    input  logic              sys_rst_n,
    vga_image_window_if.slave bus
);
    import vga_pkg::*;

    localparam logic [10:0] H_DISP_11  = 11'(H_DISP);
    localparam logic [10:0] V_DISP_11  = 11'(V_DISP);
    localparam logic [10:0] IMG_W_11   = 11'(IMG_W);
    localparam logic [10:0] IMG_H_11   = 11'(IMG_H);
    localparam logic [10:0] BORD_11    = 11'(BORDER_W);
    localparam bit          HAS_BORDER = (BORDER_W > 0);

    logic [9:0]            winX0, winY0;
    logic [10:0]           xPos, yPos, xOrg, yOrg, xBordLo, yBordLo, xOff, yOff;
    logic                  active, inWin, inBord;
    logic [ADDR_W-1:0]     romAddr_d, romAddr_q;
    logic                  inWin_q, inBord_q;
    logic [ROM_LAT-1:0]    winPipe_q, bordPipe_q;
    logic [3*CH_W-1:0]     romRgb;
    logic [3*OUT_CH_W-1:0] pixel_d, pixel_q;

    vga_win_origin #(
        .H_DISP(H_DISP), .V_DISP(V_DISP), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .X_INIT(X_INIT), .Y_INIT(Y_INIT), .STEP(STEP)
    ) u_origin (
        .driver_clk  (driver_clk),
        .sys_rst_n   (sys_rst_n),
        .pixel_xpos_i(bus.pixel_xpos),
        .pixel_ypos_i(bus.pixel_ypos),
        .move_en_i   (bus.move_en),
        .win_x0_o    (winX0),
        .win_y0_o    (winY0)
    );

    // Address is derived from coordinates every pixel, so irregular scan order cannot skew the image.
    always_comb begin
        xPos    = {1'b0, bus.pixel_xpos};
        yPos    = {1'b0, bus.pixel_ypos};
        xOrg    = {1'b0, winX0};
        yOrg    = {1'b0, winY0};
        xBordLo = (xOrg >= BORD_11) ? xOrg - BORD_11 : '0;
        yBordLo = (yOrg >= BORD_11) ? yOrg - BORD_11 : '0;
        xOff    = xPos - xOrg;
        yOff    = yPos - yOrg;
        active  = (xPos < H_DISP_11) && (yPos < V_DISP_11);
        inWin   = active && (xPos >= xOrg) && (xPos < xOrg + IMG_W_11)
                         && (yPos >= yOrg) && (yPos < yOrg + IMG_H_11);
        inBord  = HAS_BORDER && active && !inWin
                  && (xPos >= xBordLo) && (xPos < xOrg + IMG_W_11 + BORD_11)
                  && (yPos >= yBordLo) && (yPos < yOrg + IMG_H_11 + BORD_11);
        romAddr_d = inWin ? ADDR_W'(yOff) * ADDR_W'(IMG_W) + ADDR_W'(xOff) : romAddr_q;
    end

    always_comb begin
        romRgb = rgb565_expand(bus.rom_data);
        if (winPipe_q[ROM_LAT-1]) begin
            pixel_d = {romRgb[3*CH_W-1 -: OUT_CH_W], romRgb[2*CH_W-1 -: OUT_CH_W],
                       romRgb[CH_W-1 -: OUT_CH_W]};
        end else if (bordPipe_q[ROM_LAT-1]) begin
            pixel_d = bus.border_color;
        end else begin
            pixel_d = bus.bg_color;
        end
    end

    // Selects ride alongside the ROM read so they meet rom_data in the same cycle.
    always_ff @(posedge driver_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            romAddr_q  <= '0;
            inWin_q    <= 1'b0;
            inBord_q   <= 1'b0;
            winPipe_q  <= '0;
            bordPipe_q <= '0;
            pixel_q    <= '0;
        end else begin
            romAddr_q     <= romAddr_d;
            inWin_q       <= inWin;
            inBord_q      <= inBord;
            winPipe_q[0]  <= inWin_q;
            bordPipe_q[0] <= inBord_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                winPipe_q[i]  <= winPipe_q[i-1];
                bordPipe_q[i] <= bordPipe_q[i-1];
            end
            pixel_q <= pixel_d;
        end
    end

    assign bus.rom_addr   = romAddr_q;
    assign bus.pixel_data = pixel_q;
    assign bus.win_x0     = winX0;
    assign bus.win_y0     = winY0;

endmodule
